prog_loader: RTL and testbench

//  Boot-time program loader that sits directly upstream of the CPU's instruction memory.
//  It consumes a framed byte stream, for example from a UART RX, and assembles 16-bit instruction words.
//  It writes those words into imem starting at address 0 and holds the CPU in reset until a complete,

---
 rtl/prog_loader.sv | 112 +++++++++++
 tb/tb_prog_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader: framed byte stream -> 16-bit imem writes.
// Holds the CPU in reset until a checksum-verified image is loaded.
module prog_loader #(
    parameter int          ADDR_W = 8,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    input  logic              reload
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_CHK  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;
    localparam logic [2:0] S_ERR  = 3'd7;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [7:0]        r_len;
    logic [7:0]        r_hi;
    logic [7:0]        r_xor;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_waddr;
    logic [15:0]       r_wdata;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_err;
    logic              w_ready;
    logic              w_acc;
    logic              w_last;

    assign w_ready = (r_state == S_IDLE) || (r_state == S_LEN) ||
                     (r_state == S_HI)   || (r_state == S_LO)  ||
                     (r_state == S_CHK);
    assign w_acc   = rx_valid && w_ready;
    // Word counter is compared against N in 32 bits so ADDR_W may differ from 8.
    assign w_last  = (32'(r_cnt) + 32'd1) == 32'(r_len);

    assign rx_ready   = w_ready;
    assign imem_we    = (r_state == S_WR);
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign err        = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_acc && rx_data == SYNC) w_next = S_LEN;
            S_LEN:  if (w_acc) w_next = (rx_data == 8'd0) ? S_ERR : S_HI;
            S_HI:   if (w_acc) w_next = S_LO;
            S_LO:   if (w_acc) w_next = S_WR;
            S_WR:   w_next = w_last ? S_CHK : S_HI;
            S_CHK:  if (w_acc) w_next = (rx_data == r_xor) ? S_DONE : S_ERR;
            S_DONE: if (reload) w_next = S_IDLE;
            S_ERR:  if (reload) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_len     <= 8'd0;
            r_hi      <= 8'd0;
            r_xor     <= 8'd0;
            r_cnt     <= '0;
            r_waddr   <= '0;
            r_wdata   <= 16'd0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_done    <= (w_next == S_DONE);
            r_err     <= (w_next == S_ERR);
            r_cpu_rst <= (w_next != S_DONE);
            if (r_state == S_LEN && w_acc) begin
                r_len <= rx_data;
                r_cnt <= '0;
                r_xor <= 8'd0;
            end
            if (r_state == S_HI && w_acc) begin
                r_hi  <= rx_data;
                r_xor <= r_xor ^ rx_data;
            end
            if (r_state == S_LO && w_acc) begin
                r_wdata <= {r_hi, rx_data};
                r_waddr <= r_cnt;
                r_xor   <= r_xor ^ rx_data;
            end
            if (r_state == S_WR && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, junk, zero length,
// back-pressure and mid-frame reset.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic        reload;

    int n_tests;
    int n_fail;

    logic [7:0]  seq[$];
    logic [23:0] wq[$];
    logic [23:0] exp_w[$];

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err),
        .reload     (reload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every write; while loading, rx_ready must be low exactly in WR.
    always @(negedge clk) begin
        if (rst && imem_we) wq.push_back({imem_waddr, imem_wdata});
        if (rst && !done && !err)
            check("ready_vs_we", {31'd0, rx_ready}, {31'd0, !imem_we});
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send(seq[i]);
    endtask

    task automatic idle_rx();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input logic exp_done);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && !err && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, "_err"}, {31'd0, err}, {31'd0, !exp_done});
        check({tag, "_cpurst"}, {31'd0, cpu_rst}, {31'd0, !exp_done});
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(wq.size()), 32'(exp_w.size()));
        foreach (exp_w[i])
            if (i < wq.size())
                check({tag, "_wr"}, {8'd0, wq[i]}, {8'd0, exp_w[i]});
        wq.delete();
        exp_w.delete();
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_done", {31'd0, done}, 32'd0);
        check("reload_err", {31'd0, err}, 32'd0);
        check("reload_cpurst", {31'd0, cpu_rst}, 32'd1);
        check("reload_idle_rdy", {31'd0, rx_ready}, 32'd1);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_waddr", {24'd0, imem_waddr}, 32'd0);
        check("rst_wdata", {16'd0, imem_wdata}, 32'd0);
        check("rst_cpurst", {31'd0, cpu_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdy", {31'd0, rx_ready}, 32'd1);
        rst = 1'b1;

        // 1: good load, with latency checks on the first word and CHK
        send(8'hA5); send(8'h02); send(8'h60); send(8'h01);
        @(negedge clk);
        check("t1_we_lat", {31'd0, imem_we}, 32'd1);
        check("t1_waddr0", {24'd0, imem_waddr}, 32'd0);
        check("t1_wdata0", {16'd0, imem_wdata}, 32'h6001);
        send(8'h70); send(8'h02); send(8'h13);
        @(negedge clk);
        rx_valid = 1'b0;
        check("t1_done_lat", {31'd0, done}, 32'd1);
        check("t1_cpurst_lat", {31'd0, cpu_rst}, 32'd0);
        wait_end("t1", 1'b1);
        exp_w = '{24'h006001, 24'h017002};
        check_writes("t1");
        repeat (3) @(negedge clk);
        check("t1_hold_done", {31'd0, done}, 32'd1);
        check("t1_hold_rdy", {31'd0, rx_ready}, 32'd0);
        do_reload();

        // 2: bad checksum
        seq = '{8'hA5, 8'h02, 8'h60, 8'h01, 8'h70, 8'h02, 8'h14};
        send_seq();
        idle_rx();
        wait_end("t2", 1'b0);
        exp_w = '{24'h006001, 24'h017002};
        check_writes("t2");
        // reload outside DONE/ERR is ignored; inside it is honoured
        do_reload();

        // 3: junk before the frame, SYNC value as payload
        seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hA5, 8'h00, 8'hA5};
        send_seq();
        idle_rx();
        wait_end("t3", 1'b1);
        exp_w = '{24'h00A500};
        check_writes("t3");
        do_reload();

        // 4: zero length, then reload and a good frame
        seq = '{8'hA5, 8'h00};
        send_seq();
        idle_rx();
        wait_end("t4z", 1'b0);
        check_writes("t4z");
        do_reload();
        seq = '{8'hA5, 8'h02, 8'h60, 8'h01, 8'h70, 8'h02, 8'h13};
        send_seq();
        idle_rx();
        wait_end("t4", 1'b1);
        exp_w = '{24'h006001, 24'h017002};
        check_writes("t4");
        do_reload();

        // 5: rx_valid held high across the whole 3-word frame
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                8'h77};
        send_seq();
        idle_rx();
        wait_end("t5", 1'b1);
        exp_w = '{24'h001122, 24'h013344, 24'h025566};
        check_writes("t5");
        do_reload();

        // 6: reset after the HI byte of word 1
        seq = '{8'hA5, 8'h02, 8'h60};
        send_seq();
        idle_rx();
        rst = 1'b0;
        #1;
        check("t6_cpurst", {31'd0, cpu_rst}, 32'd1);
        check("t6_we", {31'd0, imem_we}, 32'd0);
        check("t6_rdy", {31'd0, rx_ready}, 32'd1);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        // a non-SYNC byte must be dropped: FSM is back in IDLE
        seq = '{8'h01, 8'hA5, 8'h02, 8'h60, 8'h01, 8'h70, 8'h02, 8'h13};
        send_seq();
        idle_rx();
        wait_end("t6", 1'b1);
        exp_w = '{24'h006001, 24'h017002};
        check_writes("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
